// File: rtl/conv_pkg.sv
// Shared constants and the patch packing helper for the conv_3_3 datapath.
// pack_patch places w[0] (top-left) in the MSBs and w[8] (bottom-right) in the LSBs.
package conv_pkg;

    localparam int PIX_W   = 16;
    localparam int K       = 3;
    localparam int PATCH_W = K * K * PIX_W;

    typedef logic [PIX_W-1:0] pix_t;

    function automatic logic [PATCH_W-1:0] pack_patch(input pix_t w [K*K]);
        logic [PATCH_W-1:0] p;
        p = '0;
        for (int k = 0; k < K * K; k++) begin
            p[(K*K-1-k)*PIX_W +: PIX_W] = w[k];
        end
        return p;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image row of pixel storage: registered write, combinational read of the
// old contents at the same address (read-before-write within a cycle).
module conv_line_buf #(
    parameter int PIX_W = 16,
    parameter int IMG_W = 8,
    parameter int AW    = $clog2(IMG_W)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [IMG_W];

    // NOTE: storage arrays carry no reset; stale contents are never used because
    // the row/column gating upstream masks them until they have been rewritten.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/conv_patch_gen.sv
// Raster pixel stream to 3x3 sliding-window patches (stride 1, no padding),
// with valid/ready flow control and a single output register.
module conv_patch_gen
    import conv_pkg::K;
#(
    parameter int PIX_W = conv_pkg::PIX_W,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic [PIX_W-1:0]       in_pixel,
    input  logic                   in_sof,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [K*K*PIX_W-1:0]   PATCH,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]          col_q, col_d, cur_col;
    logic [RW-1:0]          row_q, row_d, cur_row;
    logic [PIX_W-1:0]       lb0_rd, lb1_rd;
    logic [PIX_W-1:0]       win_q [K][K];
    logic [PIX_W-1:0]       win_d [K][K];
    logic [K*K*PIX_W-1:0]   patch_q, patch_d;
    logic                   out_valid_q, out_last_q, last_d;
    logic                   accept, emit;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    assign cur_col = in_sof ? '0 : col_q;
    assign cur_row = in_sof ? '0 : row_q;
    assign emit    = accept && (cur_row >= RW'(K-1)) && (cur_col >= CW'(K-1));
    assign last_d  = (cur_row == RW'(IMG_H-1)) && (cur_col == CW'(IMG_W-1));

    conv_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb0 (
        .CLK   (CLK),
        .we    (accept),
        .addr  (cur_col),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    conv_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb1 (
        .CLK   (CLK),
        .we    (accept),
        .addr  (cur_col),
        .wdata (in_pixel),
        .rdata (lb1_rd)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        win_d   = win_q;
        col_d   = col_q;
        row_d   = row_q;
        patch_d = '0;
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
            end
            win_d[0][K-1] = lb0_rd;
            win_d[1][K-1] = lb1_rd;
            win_d[2][K-1] = in_pixel;
            if (cur_col == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                patch_d[(K*K-1-(i*K+j))*PIX_W +: PIX_W] = win_d[i][j];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '{default: '0};
            patch_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
            // A new window reloads the register even while the old one transfers.
            if (emit) begin
                patch_q     <= patch_d;
                out_valid_q <= 1'b1;
                out_last_q  <= last_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign PATCH     = patch_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_patch_gen.sv
// Directed bench for conv_patch_gen: a 4x4 and an 8x8 instance share stimulus,
// a select bit routes in_valid and picks which outputs are observed.
module tb_conv_patch_gen;

    localparam int PW = 16;
    localparam int PB = 9 * PW;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic [PW-1:0] in_pixel;
    logic          in_sof, in_valid, out_ready;
    bit            sel, toggle_mode;

    logic          in_valid4, in_valid8;
    logic          in_ready4, out_valid4, out_last4;
    logic          in_ready8, out_valid8, out_last8;
    logic [PB-1:0] patch4, patch8;
    logic          in_ready_m, out_valid_m, out_last_m;
    logic [PB-1:0] patch_m;

    int checks = 0;
    int errors = 0;

    logic [PB-1:0] q_patch [$];
    bit            q_last [$];
    int            stall_events = 0;
    int            stall_viol = 0;
    bit            was_stalled = 1'b0;
    logic [PB:0]   held;

    int exp4 [4][9] = '{
        '{1, 2, 3, 5, 6, 7, 9, 10, 11},
        '{2, 3, 4, 6, 7, 8, 10, 11, 12},
        '{5, 6, 7, 9, 10, 11, 13, 14, 15},
        '{6, 7, 8, 10, 11, 12, 14, 15, 16}
    };
    int exp_sum [4] = '{54, 63, 90, 99};

    always #5 CLK = ~CLK;

    assign in_valid4   = in_valid && !sel;
    assign in_valid8   = in_valid && sel;
    assign in_ready_m  = sel ? in_ready8  : in_ready4;
    assign out_valid_m = sel ? out_valid8 : out_valid4;
    assign out_last_m  = sel ? out_last8  : out_last4;
    assign patch_m     = sel ? patch8     : patch4;

    conv_patch_gen #(.PIX_W(PW), .IMG_W(4), .IMG_H(4)) dut4 (
        .CLK(CLK), .rst_n(rst_n), .in_pixel(in_pixel), .in_sof(in_sof),
        .in_valid(in_valid4), .in_ready(in_ready4), .PATCH(patch4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_last(out_last4)
    );

    conv_patch_gen #(.PIX_W(PW), .IMG_W(8), .IMG_H(8)) dut8 (
        .CLK(CLK), .rst_n(rst_n), .in_pixel(in_pixel), .in_sof(in_sof),
        .in_valid(in_valid8), .in_ready(in_ready8), .PATCH(patch8),
        .out_valid(out_valid8), .out_ready(out_ready), .out_last(out_last8)
    );

    // Transfer log and stall-stability monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (!rst_n) begin
            was_stalled = 1'b0;
        end else begin
            if (was_stalled && (!out_valid_m || {out_last_m, patch_m} !== held)) begin
                stall_viol++;
            end
            if (out_valid_m && out_ready) begin
                q_patch.push_back(patch_m);
                q_last.push_back(out_last_m);
            end
            if (out_valid_m && !out_ready) begin
                stall_events++;
                if (in_ready_m) stall_viol++;
                held        = {out_last_m, patch_m};
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
        end
    end

    function automatic logic [PB-1:0] pk(input int v [9]);
        logic [PB-1:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[(8-k)*PW +: PW] = PW'(v[k]);
        return r;
    endfunction

    function automatic int psum(input logic [PB-1:0] p);
        int s;
        s = 0;
        for (int k = 0; k < 9; k++) s += int'(p[k*PW +: PW]);
        return s;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        if (toggle_mode) out_ready = !out_ready;
    endtask

    task automatic send_pixel(input int v, input bit sof);
        bit rdy;
        in_pixel = PW'(v);
        in_sof   = sof;
        in_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge CLK);
            rdy = in_ready_m;
            tick();
            if (rdy) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout pixel=%0d not accepted within 64 cycles", v);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
        out_ready = 1'b1; sel = 1'b0; toggle_mode = 1'b0;
        repeat (3) tick();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4 got %b want 0", out_valid4); end
        checks++; if (out_last4 !== 1'b0) begin errors++; $display("FAIL reset_last4 got %b want 0", out_last4); end
        checks++; if (patch4 !== '0) begin errors++; $display("FAIL reset_patch4 got %h want 0", patch4); end
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready4 got %b want 1", in_ready4); end
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid8 got %b want 0", out_valid8); end
        checks++; if (patch8 !== '0) begin errors++; $display("FAIL reset_patch8 got %h want 0", patch8); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_4x4();
        int base;
        int v [9];
        sel = 1'b0; out_ready = 1'b1; toggle_mode = 1'b0;
        base = q_patch.size();
        for (int p = 1; p <= 16; p++) send_pixel(p, p == 1);
        drain();
        checks++;
        if (q_patch.size() - base != 4) begin
            errors++; $display("FAIL basic_count got %0d want 4", q_patch.size() - base);
        end
        for (int k = 0; k < 4 && base + k < q_patch.size(); k++) begin
            for (int i = 0; i < 9; i++) v[i] = exp4[k][i];
            checks++;
            if (q_patch[base+k] !== pk(v)) begin
                errors++; $display("FAIL basic_patch%0d got %h want %h", k, q_patch[base+k], pk(v));
            end
            checks++;
            if (q_last[base+k] !== (k == 3)) begin
                errors++; $display("FAIL basic_last%0d got %b want %b", k, q_last[base+k], k == 3);
            end
            checks++;
            if (psum(q_patch[base+k]) != exp_sum[k]) begin
                errors++; $display("FAIL basic_sum%0d got %0d want %0d", k, psum(q_patch[base+k]), exp_sum[k]);
            end
        end
    endtask

    task automatic test_stall();
        int base, sv0, se0;
        int v [9];
        sel = 1'b0; out_ready = 1'b1; toggle_mode = 1'b1;
        base = q_patch.size();
        sv0  = stall_viol;
        se0  = stall_events;
        for (int p = 1; p <= 16; p++) send_pixel(p, p == 1);
        drain();
        toggle_mode = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if (q_patch.size() - base != 4) begin
            errors++; $display("FAIL stall_count got %0d want 4", q_patch.size() - base);
        end
        for (int k = 0; k < 4 && base + k < q_patch.size(); k++) begin
            for (int i = 0; i < 9; i++) v[i] = exp4[k][i];
            checks++;
            if (q_patch[base+k] !== pk(v)) begin
                errors++; $display("FAIL stall_patch%0d got %h want %h", k, q_patch[base+k], pk(v));
            end
            checks++;
            if (q_last[base+k] !== (k == 3)) begin
                errors++; $display("FAIL stall_last%0d got %b want %b", k, q_last[base+k], k == 3);
            end
        end
        checks++;
        if (stall_viol != sv0) begin
            errors++; $display("FAIL stall_stability got %0d violations want 0", stall_viol - sv0);
        end
        checks++;
        if (stall_events - se0 < 2) begin
            errors++; $display("FAIL stall_exercised got %0d stall cycles want >=2", stall_events - se0);
        end
    endtask

    task automatic test_back_to_back();
        int base, kk, top, left;
        int v [9];
        int f2 [9] = '{1, 2, 3, 9, 10, 11, 17, 18, 19};
        sel = 1'b1; out_ready = 1'b1; toggle_mode = 1'b0;
        base = q_patch.size();
        for (int f = 0; f < 2; f++) begin
            for (int p = 1; p <= 64; p++) send_pixel(p, p == 1);
        end
        drain();
        checks++;
        if (q_patch.size() - base != 72) begin
            errors++; $display("FAIL b2b_count got %0d want 72", q_patch.size() - base);
        end
        for (int k = 0; k < 72 && base + k < q_patch.size(); k++) begin
            kk   = k % 36;
            top  = kk / 6;
            left = kk % 6;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) v[i*3+j] = (top + i) * 8 + left + j + 1;
            checks++;
            if (q_patch[base+k] !== pk(v)) begin
                errors++; $display("FAIL b2b_patch%0d got %h want %h", k, q_patch[base+k], pk(v));
            end
            checks++;
            if (q_last[base+k] !== (kk == 35)) begin
                errors++; $display("FAIL b2b_last%0d got %b want %b", k, q_last[base+k], kk == 35);
            end
        end
        if (base + 36 < q_patch.size()) begin
            checks++;
            if (q_patch[base+36] !== pk(f2)) begin
                errors++; $display("FAIL b2b_frame2_first got %h want %h", q_patch[base+36], pk(f2));
            end
        end
        sel = 1'b0;
        tick();
    endtask

    task automatic test_sof_restart();
        int base;
        int v [9];
        sel = 1'b0; out_ready = 1'b1; toggle_mode = 1'b0;
        base = q_patch.size();
        for (int p = 1; p <= 10; p++) send_pixel(p, p == 1);
        for (int p = 101; p <= 116; p++) send_pixel(p, p == 101);
        drain();
        checks++;
        if (q_patch.size() - base != 4) begin
            errors++; $display("FAIL sof_count got %0d want 4", q_patch.size() - base);
        end
        for (int k = 0; k < 4 && base + k < q_patch.size(); k++) begin
            for (int i = 0; i < 9; i++) v[i] = exp4[k][i] + 100;
            checks++;
            if (q_patch[base+k] !== pk(v)) begin
                errors++; $display("FAIL sof_patch%0d got %h want %h", k, q_patch[base+k], pk(v));
            end
            checks++;
            if (q_last[base+k] !== (k == 3)) begin
                errors++; $display("FAIL sof_last%0d got %b want %b", k, q_last[base+k], k == 3);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int v [9];
        sel = 1'b0; out_ready = 1'b1; toggle_mode = 1'b0;
        for (int p = 1; p <= 10; p++) send_pixel(p, p == 1);
        out_ready = 1'b0;
        send_pixel(11, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (out_valid_m !== 1'b1) begin
            errors++; $display("FAIL midrst_pending got out_valid=%b want 1", out_valid_m);
        end
        rst_n = 1'b0;
        tick();
        checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid_m); end
        checks++; if (patch_m !== '0) begin errors++; $display("FAIL midrst_patch got %h want 0", patch_m); end
        checks++; if (out_last_m !== 1'b0) begin errors++; $display("FAIL midrst_last got %b want 0", out_last_m); end
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        base = q_patch.size();
        for (int p = 1; p <= 16; p++) send_pixel(p, 1'b0);
        drain();
        checks++;
        if (q_patch.size() - base != 4) begin
            errors++; $display("FAIL midrst_count got %0d want 4", q_patch.size() - base);
        end
        for (int k = 0; k < 4 && base + k < q_patch.size(); k++) begin
            for (int i = 0; i < 9; i++) v[i] = exp4[k][i];
            checks++;
            if (q_patch[base+k] !== pk(v)) begin
                errors++; $display("FAIL midrst_patch%0d got %h want %h", k, q_patch[base+k], pk(v));
            end
            checks++;
            if (q_last[base+k] !== (k == 3)) begin
                errors++; $display("FAIL midrst_last%0d got %b want %b", k, q_last[base+k], k == 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_4x4();
        test_stall();
        test_back_to_back();
        test_sof_restart();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
